cpu_log_emitter: RTL and testbench
==================================

Name: cpu_log_emitter

Overview:
- Upstream stage of the CPU log-line checker.
- Accepts one write-back event per handshake: either a register write or a memory write.
- Serialises the event into the ASCII log-line grammar, one character per clock, on an 8-bit char stream that feeds the checker directly.
- Used to produce legal stimulus for the checker and as the trace printer of the simulated CPU.

Parameters:
- IDLE_CHAR, 8'h20, character driven whenever no record is being emitted; must never be '^'.
- GAP, 0, minimum number of IDLE_CHAR cycles inserted after each '#' before in_ready returns high (0..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; reset==0 clears all state immediately.
- in_valid  in  1  event available.
- in_ready  out  1  block can accept an event this cycle.
- in_kind  in  1  0 = register write, 1 = memory write.
- in_time  in  16  four BCD digits, most significant digit in [15:12].
- in_pc  in  32  program counter.
- in_dst  in  32  register write: [4:0] is the register number and [31:5] is ignored; memory write: the address.
- in_data  in  32  write data.
- char  out  8  registered output character.
- char_valid  out  1  high while char belongs to a record.
- rec_type  out  2  on the '#' cycle: 1 for a register record, 2 for a memory record; 0 otherwise.
- err  out  1  one-cycle pulse: accepted event rejected because of an invalid BCD digit.

Behaviour:
- Reset values:
  - char = IDLE_CHAR, char_valid = 0, rec_type = 0, err = 0.
  - in_ready = 1, FSM state = IDLE.
- Reset asserted mid-record aborts the record; no partial continuation after release.
- Handshake:
  - An event is accepted on a rising edge where in_valid and in_ready are both 1.
  - in_ready is 1 only in IDLE and 0 from the edge after acceptance until emission plus gap end.
  - Inputs are captured at acceptance; later input changes have no effect on the record.
- Latency: '^' appears on char in the cycle immediately after acceptance, then one character per cycle with no bubbles.
- Register record: '^' T '@' P ':' ' ' '$' R ' ' '<' '=' ' ' D '#'.
- Memory record: '^' T '@' P ':' ' ' '*' A ' ' '<' '=' ' ' D '#'.
- Field rules:
  - T: time in decimal with leading zeros suppressed, 1..4 digits. Time 0000 emits "0".
  - P, A, D: exactly 8 lowercase hex digits, most significant first, leading zeros kept.
  - R: register number in decimal, 1..2 digits, no leading zero (0..31).
- Record length: 26+T+R characters for a register record, 34+T for a memory record, where T and R are digit counts.
- FSM states: IDLE, CARET, TIME, AT, PC, COLON, SP0, SIGIL, REGNUM, ADDR, SP1, LT, EQ, SP2, DATA, HASH, GAP.
  - A single 4-bit digit counter indexes multi-digit fields and is reloaded on each field entry.
  - TIME starts at the first nonzero BCD digit, or at digit 0 if all digits are zero.
  - SIGIL goes to REGNUM when in_kind is 0 and to ADDR when it is 1.
  - HASH goes to GAP if GAP>0, otherwise to IDLE.
  - GAP counts GAP cycles of IDLE_CHAR, then goes to IDLE.
- Register number to decimal conversion is by compare/subtract of 10, 20 and 30; no divider.
- On the HASH cycle rec_type = 1 for a register record or 2 for a memory record; rec_type is 0 on all other cycles.
- Invalid BCD:
  - Applies when any in_time nibble > 9 at acceptance.
  - No record is emitted; err pulses on the next cycle and char stays IDLE_CHAR.
  - in_ready returns to 1 the cycle after the err pulse.
- Back-to-back: with GAP=0 and in_valid held high, the next event is accepted on the cycle after '#' is driven. The next '^' follows '#' after exactly one IDLE_CHAR.

Decomposition:
- Shared package cpu_log_pkg holds:
  - ASCII constants: CH_CARET, CH_AT, CH_COLON, CH_SPACE, CH_DOLLAR, CH_STAR, CH_LT, CH_EQ, CH_HASH.
  - The state enum.
  - Record-kind constants REC_REG=1 and REC_MEM=2, shared with the checker.
- Sub-module: nibble_to_ascii, a combinational map of a 4-bit value to '0'-'9' / 'a'-'f', reused for BCD and hex digits.

Test Plan:
- Register record: kind=0, time=16'h0042, pc=32'h00003000, dst=5, data=32'hdeadbeef. Required char sequence is "^42@00003000: $5 <= deadbeef#" (29 chars); rec_type=1 on the '#' cycle; in_ready=0 throughout.
- Memory record: kind=1, time=16'h0000, pc=32'h0000300c, dst=32'h0000001c, data=32'h00000000. Required sequence is "^0@0000300c: *0000001c <= 00000000#" (35 chars); rec_type=2 on '#'.
- Register 31 with time 16'h9999 emits "$31" and "9999". The checker output connected downstream reads 1 one cycle after '#'.
- Invalid BCD (time=16'h00a1): err pulses once; no '^' appears; char_valid stays 0; in_ready=1 two cycles after acceptance.
- GAP=3 with in_valid held high for two events: exactly 3 IDLE_CHAR cycles then one IDLE cycle precede the second '^'.
- reset pulled low in the middle of the PC field: char = 8'h20 asynchronously. After release in_ready=1 and the next event emits a complete record starting with '^'.

Source files
------------

// File: rtl/cpu_log_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_log_pkg: ASCII constants, emitter state encoding and record kinds      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_log_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;

  // Record kinds are shared with the downstream checker.
  localparam logic [1:0] REC_NONE = 2'd0;
  localparam logic [1:0] REC_REG  = 2'd1;
  localparam logic [1:0] REC_MEM  = 2'd2;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'd0,
    ST_CARET  = 5'd1,
    ST_TIME   = 5'd2,
    ST_AT     = 5'd3,
    ST_PC     = 5'd4,
    ST_COLON  = 5'd5,
    ST_SP0    = 5'd6,
    ST_SIGIL  = 5'd7,
    ST_REGNUM = 5'd8,
    ST_ADDR   = 5'd9,
    ST_SP1    = 5'd10,
    ST_LT     = 5'd11,
    ST_EQ     = 5'd12,
    ST_SP2    = 5'd13,
    ST_DATA   = 5'd14,
    ST_HASH   = 5'd15,
    ST_GAP    = 5'd16
  } state_t;

  function automatic logic bcd_invalid(input logic [15:0] t);
    return (t[15:12] > 4'd9) || (t[11:8] > 4'd9) || (t[7:4] > 4'd9) || (t[3:0] > 4'd9);
  endfunction

  // Index of the most significant nonzero BCD digit; digit 0 when all are zero.
  function automatic logic [3:0] time_first_digit(input logic [15:0] t);
    if (t[15:12] != 4'd0)    return 4'd3;
    else if (t[11:8] != 4'd0) return 4'd2;
    else if (t[7:4] != 4'd0)  return 4'd1;
    else                      return 4'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_log_emitter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_log_emitter_if: write-back event handshake into the log emitter        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface cpu_log_emitter_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [15:0] in_time;
  logic [31:0] in_pc;
  logic [31:0] in_dst;
  logic [31:0] in_data;

  modport master (output in_valid, in_kind, in_time, in_pc, in_dst, in_data, input in_ready);
  modport slave  (input in_valid, in_kind, in_time, in_pc, in_dst, in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/nibble_to_ascii.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibble_to_ascii: 4-bit value to '0'-'9' / 'a'-'f'                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nibble_to_ascii (
  input  wire logic [3:0] i_nibble,
  output logic      [7:0] o_ascii
);
  assign o_ascii = (i_nibble < 4'd10) ? (8'h30 + {4'h0, i_nibble})
                                      : (8'h57 + {4'h0, i_nibble});
endmodule
`default_nettype wire

// File: rtl/cpu_log_emitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_log_emitter: serialises register/memory write-back events into ASCII   |
// | log lines, one character per clock. Revision: 1.0                          |
// +----------------------------------------------------------------------------+
module cpu_log_emitter
  import cpu_log_pkg::*;
#(
  parameter logic [7:0]  IDLE_CHAR = 8'h20,
  parameter int unsigned GAP       = 0
) (
  input  wire logic        clk,
  input  wire logic        reset,
  cpu_log_emitter_if.slave bus,
  output logic      [7:0]  char,
  output logic             char_valid,
  output logic      [1:0]  rec_type,
  output logic             err
);

  localparam logic [3:0] C_GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_kind, r_bad;
  logic [15:0] r_time;
  logic [31:0] r_pc, r_dst, r_data;

  logic        w_accept, w_bad_nxt;
  logic [4:0]  w_reg;
  logic [3:0]  w_tens, w_ones, w_nib;
  logic [7:0]  w_nib_ascii, w_char_nxt;
  logic        w_valid_nxt, w_err_nxt;
  logic [1:0]  w_rec_nxt;

  assign bus.in_ready = (r_state == ST_IDLE);
  assign w_accept     = bus.in_valid && (r_state == ST_IDLE);
  assign w_bad_nxt    = w_accept ? bcd_invalid(bus.in_time) : r_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kind <= 1'b0;
      r_bad  <= 1'b0;
      r_time <= 16'd0;
      r_pc   <= 32'd0;
      r_dst  <= 32'd0;
      r_data <= 32'd0;
    end else if (w_accept) begin
      r_kind <= bus.in_kind;
      r_bad  <= bcd_invalid(bus.in_time);
      r_time <= bus.in_time;
      r_pc   <= bus.in_pc;
      r_dst  <= bus.in_dst;
      r_data <= bus.in_data;
    end
  end

  // Register number to two decimal digits by threshold compare and subtract.
  assign w_reg = r_dst[4:0];
  always_comb begin
    if (w_reg >= 5'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(w_reg - 5'd30);
    end else if (w_reg >= 5'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(w_reg - 5'd20);
    end else if (w_reg >= 5'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(w_reg - 5'd10);
    end else begin
      w_tens = 4'd0;
      w_ones = w_reg[3:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_CARET;
      ST_CARET: begin
        if (r_bad) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_TIME;
          w_cnt_nxt   = time_first_digit(r_time);
        end
      end
      ST_TIME:  if (r_cnt == 4'd0) w_state_nxt = ST_AT; else w_cnt_nxt = r_cnt - 4'd1;
      ST_AT: begin
        w_state_nxt = ST_PC;
        w_cnt_nxt   = 4'd7;
      end
      ST_PC:    if (r_cnt == 4'd0) w_state_nxt = ST_COLON; else w_cnt_nxt = r_cnt - 4'd1;
      ST_COLON: w_state_nxt = ST_SP0;
      ST_SP0:   w_state_nxt = ST_SIGIL;
      ST_SIGIL: begin
        if (r_kind) begin
          w_state_nxt = ST_ADDR;
          w_cnt_nxt   = 4'd7;
        end else begin
          w_state_nxt = ST_REGNUM;
          w_cnt_nxt   = (w_tens != 4'd0) ? 4'd1 : 4'd0;
        end
      end
      ST_REGNUM: if (r_cnt == 4'd0) w_state_nxt = ST_SP1; else w_cnt_nxt = r_cnt - 4'd1;
      ST_ADDR:   if (r_cnt == 4'd0) w_state_nxt = ST_SP1; else w_cnt_nxt = r_cnt - 4'd1;
      ST_SP1:    w_state_nxt = ST_LT;
      ST_LT:     w_state_nxt = ST_EQ;
      ST_EQ:     w_state_nxt = ST_SP2;
      ST_SP2: begin
        w_state_nxt = ST_DATA;
        w_cnt_nxt   = 4'd7;
      end
      ST_DATA:   if (r_cnt == 4'd0) w_state_nxt = ST_HASH; else w_cnt_nxt = r_cnt - 4'd1;
      ST_HASH: begin
        if (GAP > 0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = C_GAP_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP:    if (r_cnt == 4'd0) w_state_nxt = ST_IDLE; else w_cnt_nxt = r_cnt - 4'd1;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are computed for the state being entered.
  always_comb begin
    w_nib = 4'd0;
    case (w_state_nxt)
      ST_TIME:   w_nib = r_time[{w_cnt_nxt[1:0], 2'b00} +: 4];
      ST_PC:     w_nib = r_pc[{w_cnt_nxt[2:0], 2'b00} +: 4];
      ST_ADDR:   w_nib = r_dst[{w_cnt_nxt[2:0], 2'b00} +: 4];
      ST_DATA:   w_nib = r_data[{w_cnt_nxt[2:0], 2'b00} +: 4];
      ST_REGNUM: w_nib = (w_cnt_nxt == 4'd1) ? w_tens : w_ones;
      default:   w_nib = 4'd0;
    endcase
  end

  nibble_to_ascii u_nib (
    .i_nibble (w_nib),
    .o_ascii  (w_nib_ascii)
  );

  always_comb begin
    w_char_nxt  = IDLE_CHAR;
    w_valid_nxt = 1'b1;
    w_rec_nxt   = REC_NONE;
    w_err_nxt   = 1'b0;
    case (w_state_nxt)
      ST_IDLE, ST_GAP: w_valid_nxt = 1'b0;
      ST_CARET: begin
        if (w_bad_nxt) begin
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b1;
        end else begin
          w_char_nxt  = CH_CARET;
        end
      end
      ST_TIME, ST_PC, ST_REGNUM, ST_ADDR, ST_DATA: w_char_nxt = w_nib_ascii;
      ST_AT:                   w_char_nxt = CH_AT;
      ST_COLON:                w_char_nxt = CH_COLON;
      ST_SP0, ST_SP1, ST_SP2:  w_char_nxt = CH_SPACE;
      ST_SIGIL:                w_char_nxt = r_kind ? CH_STAR : CH_DOLLAR;
      ST_LT:                   w_char_nxt = CH_LT;
      ST_EQ:                   w_char_nxt = CH_EQ;
      ST_HASH: begin
        w_char_nxt = CH_HASH;
        w_rec_nxt  = r_kind ? REC_MEM : REC_REG;
      end
      default:                 w_valid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char       <= IDLE_CHAR;
      char_valid <= 1'b0;
      rec_type   <= REC_NONE;
      err        <= 1'b0;
    end else begin
      char       <= w_char_nxt;
      char_valid <= w_valid_nxt;
      rec_type   <= w_rec_nxt;
      err        <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_log_emitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_log_emitter: directed and random records against a string model     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cpu_log_emitter;
  import cpu_log_pkg::*;

  localparam logic [7:0] IDLE = 8'h20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_log_emitter_if bus0 ();
  cpu_log_emitter_if bus3 ();

  logic [7:0] char0, char3;
  logic       cv0, cv3, err0, err3;
  logic [1:0] rt0, rt3;

  cpu_log_emitter #(.IDLE_CHAR(IDLE), .GAP(0)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0),
    .char(char0), .char_valid(cv0), .rec_type(rt0), .err(err0)
  );

  cpu_log_emitter #(.IDLE_CHAR(IDLE), .GAP(3)) dut3 (
    .clk(clk), .reset(rst_n), .bus(bus3),
    .char(char3), .char_valid(cv3), .rec_type(rt3), .err(err3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string expv);
    checks++;
    assert (obs == expv) else begin
      failures++;
      $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, obs, expv);
    end
  endtask

  // Reference: the log line written straight from the grammar.
  function automatic string exp_rec(input logic k, input logic [15:0] t,
                                    input logic [31:0] pc, input logic [31:0] dst,
                                    input logic [31:0] data);
    int tv;
    tv = int'(t[15:12]) * 1000 + int'(t[11:8]) * 100 + int'(t[7:4]) * 10 + int'(t[3:0]);
    if (k) return $sformatf("^%0d@%08h: *%08h <= %08h#", tv, pc, dst, data);
    else   return $sformatf("^%0d@%08h: $%0d <= %08h#", tv, pc, dst[4:0], data);
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] t;
    int lz;
    lz = $urandom_range(0, 4);
    for (int i = 0; i < 4; i++)
      t[i*4 +: 4] = (i >= 4 - lz) ? 4'd0 : 4'($urandom_range(0, 9));
    return t;
  endfunction

  task automatic drive(input int sel, input logic v, input logic k, input logic [15:0] t,
                       input logic [31:0] pc, input logic [31:0] dst, input logic [31:0] data);
    if (sel == 0) begin
      bus0.in_valid = v; bus0.in_kind = k; bus0.in_time = t;
      bus0.in_pc = pc; bus0.in_dst = dst; bus0.in_data = data;
    end else begin
      bus3.in_valid = v; bus3.in_kind = k; bus3.in_time = t;
      bus3.in_pc = pc; bus3.in_dst = dst; bus3.in_data = data;
    end
  endtask

  // One record on the GAP=0 instance; entered and left at posedge+1.
  task automatic do_record0(input string tag, input logic k, input logic [15:0] t,
                            input logic [31:0] pc, input logic [31:0] dst, input logic [31:0] data);
    string expv, obs;
    int    n;
    bit    ready_ok, valid_ok, rt_ok;
    logic [1:0] rt_exp;
    expv   = exp_rec(k, t, pc, dst, data);
    rt_exp = k ? REC_MEM : REC_REG;
    drive(0, 1'b1, k, t, pc, dst, data);
    chk({tag, "_ready_before"}, 64'(bus0.in_ready), 64'd1);
    @(posedge clk); #1;
    // Changing inputs after acceptance must not disturb the record.
    drive(0, 1'b0, ~k, 16'($urandom), $urandom, $urandom, $urandom);
    obs = ""; ready_ok = 1; valid_ok = 1; rt_ok = 1; n = 0;
    while (n < 64) begin
      obs = $sformatf("%s%c", obs, char0);
      if (bus0.in_ready !== 1'b0) ready_ok = 0;
      if (cv0 !== 1'b1) valid_ok = 0;
      if (rt0 !== ((n == expv.len() - 1) ? rt_exp : REC_NONE)) rt_ok = 0;
      n++;
      if (char0 == CH_HASH) break;
      @(posedge clk); #1;
    end
    chk_s({tag, "_line"}, obs, expv);
    chk({tag, "_ready_low"}, 64'(ready_ok), 64'd1);
    chk({tag, "_char_valid"}, 64'(valid_ok), 64'd1);
    chk({tag, "_rec_type"}, 64'(rt_ok), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_idle_char"}, 64'(char0), 64'(IDLE));
    chk({tag, "_ready_after"}, 64'(bus0.in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ka, kb;
    logic [15:0] ta, tb2;
    logic [31:0] pa, pb, da, db, xa, xb;
    string       ea, eb, obs;

    drive(0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 32'd0);
    drive(3, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_char", 64'(char0), 64'(IDLE));
    chk("rst_valid", 64'(cv0), 64'd0);
    chk("rst_rec_type", 64'(rt0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_ready", 64'(bus0.in_ready), 64'd1);
    chk("rst_ready_gap", 64'(bus3.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_record0("reg", 1'b0, 16'h0042, 32'h00003000, 32'd5, 32'hdeadbeef);
    do_record0("mem", 1'b1, 16'h0000, 32'h0000300c, 32'h0000001c, 32'h00000000);
    do_record0("r31", 1'b0, 16'h9999, 32'h12345678, 32'd31, 32'hcafef00d);
    do_record0("r10", 1'b0, 16'h1000, 32'hffffffff, 32'hffffffea, 32'h0000000f);
    do_record0("r0", 1'b0, 16'h0009, 32'h0, 32'hffffffe0, 32'h80000001);

    // Invalid BCD digit: no record, single err pulse.
    drive(0, 1'b1, 1'b0, 16'h00a1, 32'h1, 32'd3, 32'h2);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0000, 32'h0, 32'd0, 32'h0);
    chk("bcd_err", 64'(err0), 64'd1);
    chk("bcd_char", 64'(char0), 64'(IDLE));
    chk("bcd_valid", 64'(cv0), 64'd0);
    chk("bcd_ready_low", 64'(bus0.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("bcd_err_once", 64'(err0), 64'd0);
    chk("bcd_ready", 64'(bus0.in_ready), 64'd1);
    chk("bcd_valid2", 64'(cv0), 64'd0);

    // Back-to-back with GAP=0: a single idle char between records.
    ka = 1'($urandom_range(0, 1)); ta = rand_bcd(); pa = $urandom; xa = $urandom; da = $urandom;
    kb = 1'($urandom_range(0, 1)); tb2 = rand_bcd(); pb = $urandom; xb = $urandom; db = $urandom;
    ea = exp_rec(ka, ta, pa, xa, da);
    eb = exp_rec(kb, tb2, pb, xb, db);
    drive(0, 1'b1, ka, ta, pa, xa, da);
    @(posedge clk); #1;
    obs = $sformatf("%c", char0);
    drive(0, 1'b1, kb, tb2, pb, xb, db);
    for (int i = 0; i < ea.len() + eb.len(); i++) begin
      @(posedge clk); #1;
      obs = $sformatf("%s%c", obs, char0);
      if (i == ea.len()) bus0.in_valid = 1'b0;
    end
    chk_s("b2b_trace", obs, {ea, " ", eb});
    @(posedge clk); #1;
    chk("b2b_ready_after", 64'(bus0.in_ready), 64'd1);

    // GAP=3: three gap idles plus one IDLE-state idle before the next '^'.
    ka = 1'b0; ta = 16'h0123; pa = $urandom; xa = 32'd17; da = $urandom;
    kb = 1'b1; tb2 = rand_bcd(); pb = $urandom; xb = $urandom; db = $urandom;
    ea = exp_rec(ka, ta, pa, xa, da);
    eb = exp_rec(kb, tb2, pb, xb, db);
    drive(3, 1'b1, ka, ta, pa, xa, da);
    @(posedge clk); #1;
    obs = $sformatf("%c", char3);
    drive(3, 1'b1, kb, tb2, pb, xb, db);
    for (int i = 0; i < ea.len() + eb.len() + 3; i++) begin
      @(posedge clk); #1;
      obs = $sformatf("%s%c", obs, char3);
      if (i == ea.len() + 3) bus3.in_valid = 1'b0;
    end
    chk_s("gap3_trace", obs, {ea, "    ", eb});
    @(posedge clk); #1;
    chk("gap3_valid_in_gap", 64'(cv3), 64'd0);
    chk("gap3_ready_in_gap", 64'(bus3.in_ready), 64'd0);

    // Reset in the middle of the PC field aborts the record immediately.
    drive(0, 1'b1, 1'b0, 16'h0042, 32'h00003000, 32'd5, 32'hdeadbeef);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_in_pc", 64'(char0), 64'h30);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_char", 64'(char0), 64'(IDLE));
    chk("async_rst_valid", 64'(cv0), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(bus0.in_ready), 64'd1);
    chk("post_rst_char", 64'(char0), 64'(IDLE));
    do_record0("post_rst", 1'b1, 16'h0500, 32'h0badc0de, 32'h00001000, 32'h01234567);

    for (int i = 0; i < 10; i++)
      do_record0($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), rand_bcd(),
                 $urandom, $urandom, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
